// File: rtl/dccm_mem_pkg.sv
// ---------------------------------------------------------------------------
// dccm_mem_pkg : shared types and constants for the DCCM/ICCM memory model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dccm_mem_pkg;

  typedef enum logic [0:0] {
    StInit = 1'b0,
    StRun  = 1'b1
  } state_e;

  localparam logic [1:0] ErrNone = 2'b00;
  localparam logic [1:0] ErrOor  = 2'b10;

  localparam int unsigned MaxReadLatency = 4;

endpackage

`default_nettype wire

// File: rtl/dccm_rd_pipe.sv
// ---------------------------------------------------------------------------
// dccm_rd_pipe : read valid/data/error delay line with synchronous flush
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dccm_rd_pipe
  import dccm_mem_pkg::*;
#(
  parameter int unsigned ReadLatency = 1,
  parameter int unsigned DataW       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [DataW-1:0] data_i,
  input  logic [1:0]       err_i,
  output logic             valid_o,
  output logic [DataW-1:0] data_o,
  output logic [1:0]       err_o
);

  logic             valid_q [ReadLatency];
  logic [DataW-1:0] data_q  [ReadLatency];
  logic [1:0]       err_q   [ReadLatency];

  // Data and error are zeroed when not valid so the outputs never show stale data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(ReadLatency); i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
        err_q[i]   <= ErrNone;
      end
    end else begin
      valid_q[0] <= valid_i;
      data_q[0]  <= valid_i ? data_i : '0;
      err_q[0]   <= valid_i ? err_i : ErrNone;
      for (int i = 1; i < int'(ReadLatency); i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
        err_q[i]   <= err_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[ReadLatency-1];
  assign data_o  = data_q[ReadLatency-1];
  assign err_o   = err_q[ReadLatency-1];

endmodule

`default_nettype wire

// File: rtl/dccm_mem_model.sv
// ---------------------------------------------------------------------------
// dccm_mem_model : single-port SRAM model with init sweep, grant and latency
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dccm_mem_model
  import dccm_mem_pkg::*;
#(
  parameter int unsigned      SramAw      = 11,
  parameter int unsigned      Depth       = 2**SramAw,
  parameter int unsigned      DataW       = 32,
  parameter int unsigned      ReadLatency = 1,
  parameter logic [DataW-1:0] InitValue   = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [SramAw-1:0] addr_i,
  input  logic [DataW-1:0]  wdata_i,
  input  logic [DataW-1:0]  wmask_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [DataW-1:0]  rdata_o,
  output logic [1:0]        rerror_o,
  output logic              init_done_o
);

  localparam int unsigned     IdxW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Depth - 1);

  if (ReadLatency < 1 || ReadLatency > MaxReadLatency) begin : g_bad_latency
    $error("dccm_mem_model: ReadLatency must be within 1..4");
  end

  state_e           state_q, state_d;
  logic [IdxW-1:0]  ctr_q, ctr_d;
  logic [DataW-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StInit;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    gnt_o       = 1'b0;
    init_done_o = 1'b0;
    case (state_q)
      StInit: begin
        ctr_d = ctr_q + 1'b1;
        if (ctr_q == LastIdx) begin
          state_d = StRun;
          ctr_d   = '0;
        end
      end
      StRun: begin
        gnt_o       = 1'b1;
        init_done_o = 1'b1;
      end
      default: state_d = StInit;
    endcase
  end

  // Widened compare so Depth == 2**SramAw is representable.
  logic            in_range;
  logic [IdxW-1:0] addr_idx;
  logic            accept;
  logic            wr_accept;
  logic            rd_accept;

  assign in_range  = {1'b0, addr_i} < (SramAw + 1)'(Depth);
  assign addr_idx  = addr_i[IdxW-1:0];
  assign accept    = req_i & gnt_o;
  assign wr_accept = accept & we_i & in_range;
  assign rd_accept = accept & ~we_i;

  logic [DataW-1:0] rd_word;
  logic [1:0]       rd_err;

  assign rd_word = in_range ? mem_q[addr_idx] : '0;
  assign rd_err  = in_range ? ErrNone : ErrOor;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == StInit) begin
        mem_q[ctr_q] <= InitValue;
      end else if (wr_accept) begin
        mem_q[addr_idx] <= (mem_q[addr_idx] & ~wmask_i) | (wdata_i & wmask_i);
      end
    end
  end

  dccm_rd_pipe #(
    .ReadLatency (ReadLatency),
    .DataW       (DataW)
  ) u_rd_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (rd_accept),
    .data_i  (rd_word),
    .err_i   (rd_err),
    .valid_o (rvalid_o),
    .data_o  (rdata_o),
    .err_o   (rerror_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_dccm_mem_model.sv
// ---------------------------------------------------------------------------
// tb_dccm_mem_model : three model instances (Depth/latency mixes) vs. a scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dccm_mem_model;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [10:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [31:0] wmask = '0;

  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [2:0]  done;
  logic [31:0] rdata [3];
  logic [1:0]  rerr  [3];

  always #5 clk = ~clk;

  dccm_mem_model #(.SramAw(11), .Depth(16), .DataW(32), .ReadLatency(1)) u_dut_l1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .wmask_i(wmask), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]),
    .rerror_o(rerr[0]), .init_done_o(done[0]));

  dccm_mem_model #(.SramAw(11), .Depth(16), .DataW(32), .ReadLatency(3)) u_dut_l3 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .wmask_i(wmask), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]),
    .rerror_o(rerr[1]), .init_done_o(done[1]));

  dccm_mem_model #(.SramAw(11), .Depth(12), .DataW(32), .ReadLatency(2)) u_dut_d12 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .wmask_i(wmask), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]),
    .rerror_o(rerr[2]), .init_done_o(done[2]));

  typedef struct {
    int          k;
    int          due;
    logic [31:0] data;
    logic [1:0]  err;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mmem [3][16];
  int          m_cnt [3];
  int          cyc;
  int          errors;
  int          checks;

  function automatic int dep(input int k);
    return (k == 2) ? 12 : 16;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got 0x%08h expected 0x%08h", tag, cyc, act, exp);
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 3; k++) begin
      int idx;
      chk($sformatf("gnt[%0d]", k), 32'(gnt[k]), 32'(m_cnt[k] >= dep(k)));
      chk($sformatf("init_done[%0d]", k), 32'(done[k]), 32'(m_cnt[k] >= dep(k)));
      idx = -1;
      for (int i = 0; i < sbq.size(); i++) begin
        if (sbq[i].k == k) begin
          idx = i;
          break;
        end
      end
      if (idx >= 0 && sbq[idx].due == cyc) begin
        chk($sformatf("rvalid[%0d]", k), 32'(rvalid[k]), 32'd1);
        chk($sformatf("rdata[%0d]", k), rdata[k], sbq[idx].data);
        chk($sformatf("rerror[%0d]", k), 32'(rerr[k]), 32'(sbq[idx].err));
        sbq.delete(idx);
      end else begin
        chk($sformatf("rvalid_idle[%0d]", k), 32'(rvalid[k]), 32'd0);
        chk($sformatf("rdata_idle[%0d]", k), rdata[k], 32'd0);
      end
    end
  endtask

  // Reference behaviour of the clock edge that closes the current cycle.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_cnt[k] = 0;
      end else if (m_cnt[k] < dep(k)) begin
        mmem[k][m_cnt[k]] = 32'd0;
        m_cnt[k]++;
      end else if (req) begin
        if (we) begin
          if (int'(addr) < dep(k))
            mmem[k][addr[3:0]] = (mmem[k][addr[3:0]] & ~wmask) | (wdata & wmask);
        end else begin
          exp_t e;
          e.k    = k;
          e.due  = cyc + lat(k);
          e.data = (int'(addr) < dep(k)) ? mmem[k][addr[3:0]] : 32'd0;
          e.err  = (int'(addr) < dep(k)) ? 2'b00 : 2'b10;
          sbq.push_back(e);
        end
      end
    end
    if (rst) sbq.delete();
  endtask

  task automatic step(input logic r, input logic q, input logic w, input logic [10:0] a,
                      input logic [31:0] d, input logic [31:0] m);
    @(negedge clk);
    check_outputs();
    rst   = r;
    req   = q;
    we    = w;
    addr  = a;
    wdata = d;
    wmask = m;
    model_edge();
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 11'd0, 32'd0, 32'd0);
  endtask

  task automatic rd(input logic [10:0] a);
    step(1'b0, 1'b1, 1'b0, a, 32'd0, 32'd0);
  endtask

  task automatic wr(input logic [10:0] a, input logic [31:0] d, input logic [31:0] m);
    step(1'b0, 1'b1, 1'b1, a, d, m);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    for (int k = 0; k < 3; k++) m_cnt[k] = 0;

    repeat (3) step(1'b1, 1'b0, 1'b0, 11'd0, 32'd0, 32'd0);

    // Requests during the sweep must be ignored.
    for (int i = 0; i < 10; i++) rd(11'd5);
    idle(8);

    rd(11'd5);
    idle(4);

    wr(11'd7, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    wr(11'd7, 32'h0000_1122, 32'h0000_FFFF);
    rd(11'd7);
    idle(4);

    for (int a = 0; a < 8; a++) rd(11'(a));
    idle(4);

    wr(11'd13, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
    rd(11'd13);
    rd(11'd11);
    idle(4);

    for (int i = 0; i < 60; i++) begin
      logic [10:0] a;
      logic [31:0] m;
      logic [3:0]  be;
      int          r;
      r  = int'($urandom_range(0, 16));
      a  = (r == 16) ? 11'd2047 : 11'(r);
      be = 4'($urandom_range(0, 15));
      for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{be[b]}};
      case ($urandom_range(0, 3))
        0:       idle(1);
        1:       wr(a, $urandom, m);
        default: rd(a);
      endcase
    end
    idle(4);

    wr(11'd7, 32'h1234_5678, 32'hFFFF_FFFF);
    rd(11'd1);
    rd(11'd2);
    rd(11'd7);
    step(1'b1, 1'b0, 1'b0, 11'd0, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) rd(11'd7);
    idle(16);
    rd(11'd7);
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
